// File: rtl/tx_frame_buf.sv
// tx_frame_buf: ping-pong frame buffer feeding the per-hop bit serializer.
// Bytes are packed MSB-first into 32-bit words and written into the fill bank
// while the serializer reads the other bank. The banks swap on the TOD frame
// boundary (tod_h == 0 && tod_l == 0) when a complete frame is pending.
// Optional feature macro: TX_FRAME_BUF_CRC_EN appends a CRC-32 word
// (poly 04C11DB7, init FFFFFFFF, MSB-first, no reflection, no final XOR).
module tx_frame_buf #(
    parameter logic [31:0] IDLE_WORD  = 32'h0000_0000,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic [31:0] fh_num,
    input  logic [20:0] tod_h,
    input  logic [10:0] tod_l,
    input  logic [9:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        frame_swap,
    output logic [15:0] underrun_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    // Count width: holds 0..DEPTH inclusive.
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned AW    = DEPTH_LOG2 + 1;
`ifdef TX_FRAME_BUF_CRC_EN
    // One word of every frame is reserved for the CRC.
    localparam int unsigned MIN_N = 2;
`else
    localparam int unsigned MIN_N = 1;
`endif

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_CRC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state;
    logic                  wr_sel;
    logic                  full;
    logic                  rd_valid;
    logic [CW-1:0]         wr_wc;
    logic [CW-1:0]         rd_wc;
    logic [CW-1:0]         n_lat;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [1:0]            lane;
    logic [31:0]           acc;
    logic                  started;

    logic [31:0] mem [0:2*DEPTH-1];

    logic [CW-1:0] n_fh_c;
    logic          accept_c;
    logic [31:0]   word_c;
    logic          word_done_c;
    logic          last_word_c;
    logic          boundary_c;
    logic          swap_c;
    logic          we_c;
    logic [AW-1:0] wa_c;
    logic [31:0]   wd_c;
    logic          eff_sel_c;
    logic          eff_valid_c;
    logic [CW-1:0] eff_wc_c;
    logic          in_range_c;

`ifdef TX_FRAME_BUF_CRC_EN
    logic [31:0] crc;
    logic [31:0] crc_upd_c;

    // CRC-32 update over one word, bits consumed MSB-first.
    function automatic logic [31:0] crc32_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction
`endif

    // Frame word limit, handshake, packing and boundary decode.
    always_comb begin
        n_fh_c      = (fh_num > 32'(DEPTH)) ? CW'(DEPTH) : CW'(fh_num);
        accept_c    = s_valid && s_ready;
        boundary_c  = (tod_h == 21'd0) && (tod_l == 11'd0);
        swap_c      = boundary_c && full;
        word_c      = (lane == 2'd0) ? 32'h0 : acc;
        case (lane)
            2'd0:    word_c[31:24] = s_data;
            2'd1:    word_c[23:16] = s_data;
            2'd2:    word_c[15:8]  = s_data;
            default: word_c[7:0]   = s_data;
        endcase
        word_done_c = accept_c && ((lane == 2'd3) || s_last);
        last_word_c = word_done_c &&
                      (s_last || (CW'(wr_ptr) == (n_lat - CW'(MIN_N))));
    end

`ifdef TX_FRAME_BUF_CRC_EN
    // Running CRC including the word being committed.
    always_comb begin
        crc_upd_c = crc32_word(crc, word_c);
    end
`endif

    // Bank write port: payload words while filling, CRC word after the payload.
    always_comb begin
        we_c = 1'b0;
        wa_c = {wr_sel, wr_ptr};
        wd_c = word_c;
        if (state == ST_FILL && word_done_c) begin
            we_c = 1'b1;
        end
`ifdef TX_FRAME_BUF_CRC_EN
        if (state == ST_CRC) begin
            we_c = 1'b1;
            wd_c = crc;
        end
`endif
        we_c = we_c && rst;
    end

    // Read-side view; in a swapping boundary cycle the new bank is already used.
    always_comb begin
        eff_sel_c   = swap_c ? wr_sel : ~wr_sel;
        eff_valid_c = boundary_c ? full : rd_valid;
        eff_wc_c    = swap_c ? wr_wc : rd_wc;
        in_range_c  = 32'(rd_addr) < 32'(eff_wc_c);
    end

    // Bank storage; contents are not reset, validity is tracked separately.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wa_c] <= wd_c;
        end
    end

    // Registered read data with idle substitution.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= IDLE_WORD;
        end else if (eff_valid_c && in_range_c) begin
            rd_data <= mem[{eff_sel_c, DEPTH_LOG2'(rd_addr)}];
        end else begin
            rd_data <= IDLE_WORD;
        end
    end

    // Write FSM, bank swap and underrun accounting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_FILL;
            wr_sel       <= 1'b0;
            full         <= 1'b0;
            rd_valid     <= 1'b0;
            wr_wc        <= '0;
            rd_wc        <= '0;
            n_lat        <= '0;
            wr_ptr       <= '0;
            lane         <= 2'd0;
            acc          <= 32'h0;
            started      <= 1'b0;
            s_ready      <= 1'b0;
            frame_swap   <= 1'b0;
            underrun_cnt <= 16'd0;
`ifdef TX_FRAME_BUF_CRC_EN
            crc          <= 32'hFFFF_FFFF;
`endif
        end else begin
            frame_swap <= swap_c;

            if (boundary_c) begin
                if (full) begin
                    wr_sel   <= ~wr_sel;
                    rd_valid <= 1'b1;
                    rd_wc    <= wr_wc;
                end else begin
                    rd_valid <= 1'b0;
                    if (underrun_cnt != 16'hFFFF) begin
                        underrun_cnt <= underrun_cnt + 16'd1;
                    end
                end
            end

            case (state)
                ST_FILL: begin
                    // Track fh_num until the first byte of the frame arrives.
                    if (!started && !accept_c) begin
                        n_lat   <= n_fh_c;
                        s_ready <= (n_fh_c >= CW'(MIN_N));
                    end
                    if (accept_c) begin
                        started <= 1'b1;
                        lane    <= lane + 2'd1;
                        acc     <= word_c;
                        if (word_done_c) begin
                            lane   <= 2'd0;
                            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
`ifdef TX_FRAME_BUF_CRC_EN
                            crc    <= crc_upd_c;
`endif
                        end
                        if (last_word_c) begin
                            s_ready <= 1'b0;
`ifdef TX_FRAME_BUF_CRC_EN
                            state   <= ST_CRC;
`else
                            full    <= 1'b1;
                            wr_wc   <= CW'(wr_ptr) + CW'(1);
                            state   <= ST_HOLD;
`endif
                        end
                    end
                end
                ST_CRC: begin
                    // wr_ptr already points one past the last payload word.
                    full  <= 1'b1;
                    wr_wc <= CW'(wr_ptr) + CW'(1);
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (swap_c) begin
                        state   <= ST_FILL;
                        full    <= 1'b0;
                        wr_ptr  <= '0;
                        lane    <= 2'd0;
                        acc     <= 32'h0;
                        started <= 1'b0;
                        n_lat   <= n_fh_c;
                        s_ready <= (n_fh_c >= CW'(MIN_N));
`ifdef TX_FRAME_BUF_CRC_EN
                        crc     <= 32'hFFFF_FFFF;
`endif
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_buf.sv
// Directed bench for tx_frame_buf.
module tb_tx_frame_buf;

    localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] fh_num;
    logic [20:0] tod_h;
    logic [10:0] tod_l;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic        frame_swap;
    logic [15:0] underrun_cnt;

    int tests = 0;
    int fails = 0;

    tx_frame_buf #(.IDLE_WORD(IDLE), .DEPTH_LOG2(10)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .fh_num(fh_num), .tod_h(tod_h), .tod_l(tod_l),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_swap(frame_swap),
        .underrun_cnt(underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit rdy;
        int n;
        s_data = b;
        s_valid = 1'b1;
        s_last = last;
        n = 0;
        do begin
            rdy = s_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            tests++; fails++;
            $display("FAIL send_byte_timeout byte=%h s_ready never high", b);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic boundary();
        tod_h = 21'd0;
        tod_l = 11'd0;
        tick();
        tod_h = 21'd5;
        tod_l = 11'd1;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fh_num = 32'd4;
        tick();
        tick();
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        tests++; if (rd_data !== IDLE) begin fails++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, IDLE); end
        tests++; if (frame_swap !== 1'b0) begin fails++; $display("FAIL reset_frame_swap got=%b exp=0", frame_swap); end
        tests++; if (underrun_cnt !== 16'd0) begin fails++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt); end
        rst = 1'b1;
        tick();
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL release_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_full_frame();
        logic [31:0] d;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0102_0304; exp_w[1] = 32'h0506_0708;
        exp_w[2] = 32'h090A_0B0C; exp_w[3] = 32'h0D0E_0F10;
        fh_num = 32'd4;
        do_reset();
        for (int i = 1; i <= 16; i++) send_byte(8'(i), (i == 16));
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full_hold_ready got=%b exp=0", s_ready); end
        rd(10'd0, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL full_preswap_read got=%h exp=%h", d, IDLE); end
        boundary();
        tests++; if (frame_swap !== 1'b1) begin fails++; $display("FAIL full_swap_pulse got=%b exp=1", frame_swap); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_swap got=%b exp=1", s_ready); end
        tests++; if (underrun_cnt !== 16'd0) begin fails++; $display("FAIL full_underrun got=%0d exp=0", underrun_cnt); end
        tick();
        tests++; if (frame_swap !== 1'b0) begin fails++; $display("FAIL full_swap_one_cycle got=%b exp=0", frame_swap); end
        for (int a = 0; a < 4; a++) begin
            rd(10'(a), d);
            tests++; if (d !== exp_w[a]) begin fails++; $display("FAIL full_word%0d got=%h exp=%h", a, d, exp_w[a]); end
        end
        rd(10'd4, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL full_word4_idle got=%h exp=%h", d, IDLE); end

        // Partial frame into the other bank; rd_addr held during the boundary.
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i), (i == 4));
        rd_addr = 10'd0;
        boundary();
        tests++; if (rd_data !== 32'hA1A2_A3A4) begin fails++; $display("FAIL part_boundary_read got=%h exp=A1A2A3A4", rd_data); end
        rd(10'd1, d);
        tests++; if (d !== 32'hA500_0000) begin fails++; $display("FAIL part_word1_pad got=%h exp=A5000000", d); end
        rd(10'd2, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL part_word2_idle got=%h exp=%h", d, IDLE); end
    endtask

    task automatic test_underrun();
        logic [31:0] d;
        fh_num = 32'd4;
        do_reset();
        boundary();
        tests++; if (underrun_cnt !== 16'd1) begin fails++; $display("FAIL underrun_count got=%0d exp=1", underrun_cnt); end
        tests++; if (frame_swap !== 1'b0) begin fails++; $display("FAIL underrun_no_swap got=%b exp=0", frame_swap); end
        for (int a = 0; a < 3; a++) begin
            rd(10'(a), d);
            tests++; if (d !== IDLE) begin fails++; $display("FAIL underrun_read%0d got=%h exp=%h", a, d, IDLE); end
        end
    endtask

    task automatic test_boundary_collision();
        logic [31:0] d;
        fh_num = 32'd1;
        do_reset();
        send_byte(8'hB0, 1'b0);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        s_data = 8'hB3;
        s_valid = 1'b1;
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL coll_ready_pre got=%b exp=1", s_ready); end
        boundary();
        s_valid = 1'b0;
        tests++; if (frame_swap !== 1'b0) begin fails++; $display("FAIL coll_no_swap got=%b exp=0", frame_swap); end
        tests++; if (underrun_cnt !== 16'd1) begin fails++; $display("FAIL coll_underrun got=%0d exp=1", underrun_cnt); end
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL coll_ready_low got=%b exp=0", s_ready); end
        rd(10'd0, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL coll_read_idle got=%h exp=%h", d, IDLE); end
        boundary();
        tests++; if (frame_swap !== 1'b1) begin fails++; $display("FAIL coll_next_swap got=%b exp=1", frame_swap); end
        tests++; if (underrun_cnt !== 16'd1) begin fails++; $display("FAIL coll_underrun_hold got=%0d exp=1", underrun_cnt); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL coll_ready_back got=%b exp=1", s_ready); end
        rd(10'd0, d);
        tests++; if (d !== 32'hB0B1_B2B3) begin fails++; $display("FAIL coll_word0 got=%h exp=B0B1B2B3", d); end
        rd(10'd1, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL coll_word1_idle got=%h exp=%h", d, IDLE); end
    endtask

    task automatic test_fill_limit();
        logic [31:0] d;
        fh_num = 32'd2;
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL limit_ready_low got=%b exp=0", s_ready); end
        s_data = 8'hEE;
        s_valid = 1'b1;
        tick(); tick(); tick();
        s_valid = 1'b0;
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL limit_hold_ready got=%b exp=0", s_ready); end
        boundary();
        tests++; if (frame_swap !== 1'b1) begin fails++; $display("FAIL limit_swap got=%b exp=1", frame_swap); end
        rd(10'd0, d);
        tests++; if (d !== 32'hC0C1_C2C3) begin fails++; $display("FAIL limit_word0 got=%h exp=C0C1C2C3", d); end
        rd(10'd1, d);
        tests++; if (d !== 32'hC4C5_C6C7) begin fails++; $display("FAIL limit_word1 got=%h exp=C4C5C6C7", d); end
        rd(10'd2, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL limit_word2_idle got=%h exp=%h", d, IDLE); end
        send_byte(8'hD0, 1'b1);
        boundary();
        rd(10'd0, d);
        tests++; if (d !== 32'hD000_0000) begin fails++; $display("FAIL limit_next_frame got=%h exp=D0000000", d); end
        rd(10'd1, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL limit_next_wc got=%h exp=%h", d, IDLE); end
    endtask

    task automatic test_back_to_back_reset();
        logic [31:0] d;
        int stalls;
        fh_num = 32'd1024;
        do_reset();
        stalls = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            s_data = 8'(i);
            if (s_ready !== 1'b1) stalls++;
            tick();
        end
        tests++; if (stalls != 0) begin fails++; $display("FAIL stream_stalls got=%0d exp=0", stalls); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL stream_ready_end got=%b exp=1", s_ready); end
        rst = 1'b0;
        tick();
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready got=%b exp=0", s_ready); end
        tests++; if (underrun_cnt !== 16'd0) begin fails++; $display("FAIL midreset_underrun got=%0d exp=0", underrun_cnt); end
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rd_addr = 10'd0;
        boundary();
        tests++; if (frame_swap !== 1'b0) begin fails++; $display("FAIL postreset_no_swap got=%b exp=0", frame_swap); end
        tests++; if (underrun_cnt !== 16'd1) begin fails++; $display("FAIL postreset_underrun got=%0d exp=1", underrun_cnt); end
        rd(10'd0, d);
        tests++; if (d !== IDLE) begin fails++; $display("FAIL postreset_read got=%h exp=%h", d, IDLE); end
    endtask

`ifdef TX_FRAME_BUF_CRC_EN
    task automatic test_crc();
        logic [31:0] d;
        fh_num = 32'd2;
        do_reset();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h34, 1'b1);
        tick();
        tick();
        boundary();
        tests++; if (frame_swap !== 1'b1) begin fails++; $display("FAIL crc_swap got=%b exp=1", frame_swap); end
        rd(10'd0, d);
        tests++; if (d !== 32'h3132_3334) begin fails++; $display("FAIL crc_word0 got=%h exp=31323334", d); end
        rd(10'd1, d);
        tests++; if (d !== 32'hA695_C4AA) begin fails++; $display("FAIL crc_word1 got=%h exp=A695C4AA", d); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        s_data = 8'h00;
        s_valid = 1'b0;
        s_last = 1'b0;
        fh_num = 32'd4;
        tod_h = 21'd5;
        tod_l = 11'd1;
        rd_addr = 10'd0;
        test_reset();
`ifdef TX_FRAME_BUF_CRC_EN
        test_crc();
`else
        test_full_frame();
        test_underrun();
        test_boundary_collision();
        test_fill_limit();
        test_back_to_back_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_frame_buf.md
# tx_frame_buf

Ping-pong frame buffer directly upstream of the per-hop bit serializer. Accepts a byte stream with a valid/ready handshake, packs bytes MSB-first into 32-bit words, and fills one bank while the serializer reads the other through a 10-bit word address. Banks swap on the TOD frame boundary. If no complete frame is pending at the boundary, the serializer reads an idle pattern instead of stale data.

## Interface
Parameters:
- `IDLE_WORD`, default 32'h0000_0000: word returned for an empty bank or an out-of-range address.
- `DEPTH_LOG2`, default 10: log2 of words per bank, giving 1024 words per bank and 2 banks.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  byte valid.
- `s_last`  in  1  last byte of frame, qualified by `s_valid && s_ready`.
- `s_ready`  out  1  buffer can accept a byte.
- `fh_num`  in  32  hop count per frame, equal to words per frame. Sampled at the start of each fill.
- `tod_h`  in  21  hop index within frame.
- `tod_l`  in  11  clock offset within hop.
- `rd_addr`  in  10  serializer word address.
- `rd_data`  out  32  word at `rd_addr`, registered.
- `frame_swap`  out  1  one-cycle pulse when a full bank becomes the read bank.
- `underrun_cnt`  out  16  count of frame boundaries with no pending frame. Saturates at 16'hFFFF.

## Operation
Word limit:
- `N = min(fh_num, 1024)`, latched into `n_lat` when the fill of an empty write bank begins.
- If `N == 0`: `s_ready` = 0 and the bank never fills.

Packing:
- The first accepted byte lands in bits [31:24], then [23:16], [15:8], [7:0].
- The word is written to `wr_bank[wr_ptr]` on its 4th byte, and `wr_ptr` increments.

Fill completion occurs on either condition:
- the word with `wr_ptr == n_lat-1` is written, or
- `s_last` is accepted.
- On `s_last` with a partial word, the remaining bytes are zero-padded and the word is written in the same cycle.
- Words beyond the last one written keep their previous contents. The stored word count `wc = wr_ptr+1` is saved with the bank.
- If `s_last` is not seen before N words, the fill still completes. The next accepted byte begins a new frame.

Write FSM:
- `FILL`: `s_ready` = 1 while `N != 0`. On completion, set the bank's full flag and go to `HOLD`.
- `HOLD`: `s_ready` = 0. Wait for the swap, then return to `FILL` with `wr_ptr` = 0.

Swap:
- Evaluated in the cycle where `tod_h == 0 && tod_l == 0`.
- If the write bank's full flag was already registered: exchange the read/write bank select, mark the new read bank valid with its `wc`, clear the full flag, and pulse `frame_swap`.
- Otherwise: mark the read bank invalid and increment `underrun_cnt`.

Read:
- `rd_data` = `rd_bank[rd_addr]` if the read bank is valid and `rd_addr < wc`.
- Otherwise `rd_data` = `IDLE_WORD`.

## Timing
Reset values:
- `s_ready` = 0 during reset and 1 from the first cycle after reset release.
- `rd_data` = `IDLE_WORD`, `frame_swap` = 0, `underrun_cnt` = 0.
- Both banks empty, read bank invalid, FSM in `FILL`, `wr_ptr` = 0, byte lane = 0.

Latency:
- `rd_data` has 1-cycle latency from `rd_addr`.
- The read bank is stable for a full frame, so the serializer's sample at `tod_l == 400` sees valid data.

Swap edge cases:
- A fill completing in the same cycle as the boundary is not swapped. It is counted as an underrun and swapped at the next boundary.
- The bank select changes in the boundary cycle. A read issued in that cycle returns data from the new bank one cycle later.

Other rules:
- `s_ready` falls in the cycle after the completing byte. No byte is accepted in `HOLD`.
- `s_valid` with `s_ready` = 0 has no effect. Data is held by the source.
- Reset asserted mid-fill discards the partial frame and both banks. No write is committed in the reset cycle.

## Configuration
- `TX_FRAME_BUF_CRC_EN` defined:
  - Payload capacity becomes `N-1` words.
  - Word `N-1`, or word `wc` after an early `s_last`, holds CRC-32 over all written payload bytes, including pad bytes.
  - CRC-32 parameters: polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no reflection, no final XOR.
  - The CRC word is written one cycle after the last payload word, and `wc` includes it.
  - If `N` is 0 or 1: `s_ready` = 0.
- Not defined: no CRC, and all N words carry payload.

## Test plan
1. `fh_num` = 4, send bytes 0x01..0x10 with `s_last` on 0x10, then boundary → `frame_swap` pulse. `rd_addr` 0..3 returns 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 one cycle later. `rd_addr` = 4 returns `IDLE_WORD`.
2. `fh_num` = 4, send 5 bytes 0xA1..0xA5 with `s_last` on 0xA5, then boundary → word0 = 0xA1A2A3A4, word1 = 0xA5000000, `wc` = 2.
3. Boundary with no data sent → `underrun_cnt` = 1, `rd_data` = `IDLE_WORD` for every address.
4. Complete the fill in the exact boundary cycle → `underrun_cnt` increments and there is no `frame_swap`. Next boundary → swap occurs and `s_ready` returns to 1 the cycle after.
5. Back-pressure: stream 3000 bytes with `fh_num` = 1024 → `s_ready` drops after byte 4096? No: `s_ready` drops after byte 4096 only if the bank fills. With 3000 bytes and no `s_last`, `s_ready` stays 1. Then pull `rst` low mid-fill → `s_ready` = 0, banks empty, `underrun_cnt` = 0.
6. With CRC enabled, `fh_num` = 2, send 0x31,0x32,0x33,0x34 (`s_last`) → word0 = 0x31323334, word1 = CRC-32/MPEG-2 of "1234" = 0xA695C4AA.
